gshare_fetch: RTL and testbench

GSHARE_FETCH -- requirements
Module: gshare_fetch

---
 rtl/gshare_fetch.sv | 176 +++++++++++++++++
 tb/tb_gshare_fetch.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_fetch.sv
// gshare_fetch -- single-stage instruction fetch with a gshare direction
// predictor.
//
// Each cycle the PC register addresses instruction memory. The returned word
// is predecoded (conditional branch / JAL), its direction is looked up in a
// pattern history table indexed by speculative global history XOR PC, and
// the resulting packet is registered into a one-entry output buffer with a
// valid/ready handshake. The PC then advances to the predicted target.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   imem_addr/data    fetch address (the PC) and same-cycle instruction word
//   out_*             registered fetch packet, out_valid/out_ready handshake
//   redirect_*        backend flush: restart fetch at redirect_pc
//   commit_*          resolved conditional branch, trains PHT and arch history
module gshare_fetch #(
    parameter int unsigned HIST_BITS = 10,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [1:0]  CTR_INIT  = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_branch,
    output logic        out_jump,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_target,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        commit_valid,
    input  logic        commit_taken,
    input  logic [31:0] commit_pc
);
    localparam int unsigned PHT_SIZE  = 1 << HIST_BITS;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    logic [31:0]          pc_q, pc_d;
    logic [HIST_BITS-1:0] spec_ghr_q, spec_ghr_d;
    logic [HIST_BITS-1:0] arch_ghr_q, arch_ghr_d;
    logic [1:0]           pht_q [PHT_SIZE];

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_branch_q, out_branch_d;
    logic        out_jump_q, out_jump_d;
    logic        out_pred_taken_q, out_pred_taken_d;
    logic [31:0] out_pred_target_q, out_pred_target_d;

    logic                 is_branch, is_jump;
    logic [HIST_BITS-1:0] rd_idx, wr_idx;
    logic                 pred_dir, pred_taken;
    logic [31:0]          b_imm, j_imm, pred_target;
    logic                 fire;
    logic [1:0]           ctr_old, ctr_new;

    // Only the index bits of commit_pc take part in training.
    logic unused_commit_bits;
    assign unused_commit_bits = ^{commit_pc[31:HIST_BITS+2], commit_pc[1:0]};

    // Predecode and prediction for the word at the current PC.
    always_comb begin
        is_branch = (imem_data[6:0] == OP_BRANCH);
        is_jump   = (imem_data[6:0] == OP_JAL);
        b_imm = {{19{imem_data[31]}}, imem_data[31], imem_data[7],
                 imem_data[30:25], imem_data[11:8], 1'b0};
        j_imm = {{11{imem_data[31]}}, imem_data[31], imem_data[19:12],
                 imem_data[20], imem_data[30:21], 1'b0};
        rd_idx     = spec_ghr_q ^ pc_q[HIST_BITS+1:2];
        // PHT is read from the registered array, so a same-cycle commit to
        // this index is not visible until the next cycle.
        pred_dir   = pht_q[rd_idx][1];
        pred_taken = (is_branch && pred_dir) || is_jump;
        if (is_branch && pred_dir) begin
            pred_target = pc_q + b_imm;
        end else if (is_jump) begin
            pred_target = pc_q + j_imm;
        end else begin
            pred_target = pc_q + 32'd4;
        end
    end

    // Commit-side training: saturating counter update and arch history.
    always_comb begin
        wr_idx  = arch_ghr_q ^ commit_pc[HIST_BITS+1:2];
        ctr_old = pht_q[wr_idx];
        ctr_new = ctr_old;
        if (commit_taken) begin
            if (ctr_old != 2'b11) ctr_new = ctr_old + 2'd1;
        end else begin
            if (ctr_old != 2'b00) ctr_new = ctr_old - 2'd1;
        end
        arch_ghr_d = arch_ghr_q;
        if (commit_valid) arch_ghr_d = {arch_ghr_q[HIST_BITS-2:0], commit_taken};
    end

    always_comb begin
        fire              = !redirect_valid && (!out_valid_q || out_ready);
        pc_d              = pc_q;
        spec_ghr_d        = spec_ghr_q;
        out_valid_d       = out_valid_q;
        out_pc_d          = out_pc_q;
        out_instr_d       = out_instr_q;
        out_branch_d      = out_branch_q;
        out_jump_d        = out_jump_q;
        out_pred_taken_d  = out_pred_taken_q;
        out_pred_target_d = out_pred_target_q;
        if (redirect_valid) begin
            // Speculative history restarts from the architectural history
            // including any commit landing in this same cycle.
            pc_d        = redirect_pc;
            spec_ghr_d  = arch_ghr_d;
            out_valid_d = 1'b0;
        end else if (fire) begin
            pc_d              = pred_target;
            out_valid_d       = 1'b1;
            out_pc_d          = pc_q;
            out_instr_d       = imem_data;
            out_branch_d      = is_branch;
            out_jump_d        = is_jump;
            out_pred_taken_d  = pred_taken;
            out_pred_target_d = pred_target;
            if (is_branch) spec_ghr_d = {spec_ghr_q[HIST_BITS-2:0], pred_dir};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q              <= RESET_PC;
            spec_ghr_q        <= '0;
            arch_ghr_q        <= '0;
            out_valid_q       <= 1'b0;
            out_pc_q          <= '0;
            out_instr_q       <= '0;
            out_branch_q      <= 1'b0;
            out_jump_q        <= 1'b0;
            out_pred_taken_q  <= 1'b0;
            out_pred_target_q <= '0;
        end else begin
            pc_q              <= pc_d;
            spec_ghr_q        <= spec_ghr_d;
            arch_ghr_q        <= arch_ghr_d;
            out_valid_q       <= out_valid_d;
            out_pc_q          <= out_pc_d;
            out_instr_q       <= out_instr_d;
            out_branch_q      <= out_branch_d;
            out_jump_q        <= out_jump_d;
            out_pred_taken_q  <= out_pred_taken_d;
            out_pred_target_q <= out_pred_target_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pht_q <= '{default: CTR_INIT};
        end else if (commit_valid) begin
            pht_q[wr_idx] <= ctr_new;
        end
    end

    assign imem_addr       = pc_q;
    assign out_valid       = out_valid_q;
    assign out_pc          = out_pc_q;
    assign out_instr       = out_instr_q;
    assign out_branch      = out_branch_q;
    assign out_jump        = out_jump_q;
    assign out_pred_taken  = out_pred_taken_q;
    assign out_pred_target = out_pred_target_q;

endmodule

// File: tb/tb_gshare_fetch.sv
// Self-checking bench for gshare_fetch: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural fetch/predictor model.
module tb_gshare_fetch;
    localparam int K_OTHER = 0;
    localparam int K_BR    = 1;
    localparam int K_JAL   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr, out_pred_target;
    logic        out_branch, out_jump, out_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        commit_valid, commit_taken;
    logic [31:0] commit_pc;

    always #5 clk = ~clk;

    // Instruction memory with a side table describing each word.
    logic [31:0] mem [1024];
    int          kind [1024];
    int          immv [1024];
    assign imem_data = mem[imem_addr[11:2]];

    gshare_fetch #(.HIST_BITS(10), .RESET_PC(32'h0000_0000), .CTR_INIT(2'b01)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_branch(out_branch), .out_jump(out_jump),
        .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .commit_valid(commit_valid), .commit_taken(commit_taken),
        .commit_pc(commit_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_opc, m_oinstr, m_otgt;
    int          m_spec, m_arch;
    int          m_pht [1024];
    bit          m_ov, m_obr, m_oj, m_opt;

    function automatic logic [31:0] enc_addi(int im);
        logic [11:0] v;
        v = 12'(im);
        return {v, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_br(int im);
        logic [12:0] b;
        b = 13'(im);
        return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(int im);
        logic [20:0] j;
        j = 21'(im);
        return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_other();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 4))
            0:       op = 7'b1100111; // JALR
            1:       op = 7'b0000011;
            2:       op = 7'b0100011;
            3:       op = 7'b0110111;
            default: op = 7'b0110011;
        endcase
        return {w[31:7], op};
    endfunction

    task automatic put_idx(int i, logic [31:0] w, int k, int im);
        mem[i] = w; kind[i] = k; immv[i] = im;
    endtask

    task automatic put_at(logic [31:0] addr, logic [31:0] w, int k, int im);
        put_idx(int'(addr[11:2]), w, k, im);
    endtask

    task automatic fill_addi();
        for (int i = 0; i < 1024; i++) put_idx(i, enc_addi(i), K_OTHER, 0);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_spec = 0; m_arch = 0; m_ov = 0;
        m_opc = '0; m_oinstr = '0; m_otgt = '0; m_obr = 0; m_oj = 0; m_opt = 0;
        for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int a, k, ridx, widx, na;
        bit dir, tk, fire;
        a    = int'(m_pc[11:2]);
        k    = kind[a];
        ridx = (m_spec ^ a) % 1024;
        dir  = (m_pht[ridx] >= 2);
        fire = !redirect_valid && (!m_ov || out_ready);
        na   = m_arch;
        if (commit_valid) begin
            widx = (m_arch ^ int'(commit_pc[11:2])) % 1024;
            if (commit_taken) begin
                if (m_pht[widx] < 3) m_pht[widx] = m_pht[widx] + 1;
            end else begin
                if (m_pht[widx] > 0) m_pht[widx] = m_pht[widx] - 1;
            end
            na = (m_arch * 2 + int'(commit_taken)) % 1024;
        end
        if (redirect_valid) begin
            m_pc = redirect_pc; m_ov = 0; m_spec = na;
        end else if (fire) begin
            tk       = (k == K_BR && dir) || (k == K_JAL);
            m_opc    = m_pc;
            m_oinstr = mem[a];
            m_obr    = (k == K_BR);
            m_oj     = (k == K_JAL);
            m_opt    = tk;
            m_otgt   = tk ? m_pc + 32'(immv[a]) : m_pc + 32'd4;
            m_ov     = 1;
            if (k == K_BR) m_spec = (m_spec * 2 + int'(dir)) % 1024;
            m_pc = m_otgt;
        end
        m_arch = na;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_valid = 0; redirect_pc = '0;
        commit_valid = 0; commit_taken = 0; commit_pc = '0;
        out_ready = 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 0;
        idle_inputs();
        model_reset();
        #12;
        reset = 1;
    endtask

    task automatic test_reset();
        fill_addi();
        @(posedge clk);
        #1;
        reset = 0;
        idle_inputs();
        model_reset();
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 ||
            out_branch !== 1'b0 || out_jump !== 1'b0 || out_pred_taken !== 1'b0 ||
            out_pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outs: valid=%b pc=%h instr=%h br=%b j=%b pt=%b tgt=%h, expected all zero",
                     out_valid, out_pc, out_instr, out_branch, out_jump, out_pred_taken, out_pred_target);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (imem_addr !== 32'h0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: imem_addr=%h valid=%b, expected 00000000 0", imem_addr, out_valid);
        end
        reset = 1;
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_fire: valid=%b pc=%h, expected 1 00000000", out_valid, out_pc);
        end
    endtask

    task automatic test_stream();
        fill_addi();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_pred_taken !== 1'b0 ||
                out_pred_target !== 32'(4 * i + 4)) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b pc=%h pt=%b tgt=%h, expected 1 %h 0 %h",
                         i, out_valid, out_pc, out_pred_taken, out_pred_target, 4 * i, 4 * i + 4);
            end
        end
        // PC wrap at the top of the address space
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        n_checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_redirect: valid=%b imem_addr=%h, expected 0 fffffffc", out_valid, imem_addr);
        end
        redirect_valid = 0;
        cyc();
        n_checks++;
        if (out_pc !== 32'hFFFF_FFFC || out_pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_packet: pc=%h tgt=%h, expected fffffffc 00000000", out_pc, out_pred_target);
        end
        cyc();
        n_checks++;
        if (out_pc !== 32'h0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_next: pc=%h valid=%b, expected 00000000 1", out_pc, out_valid);
        end
    endtask

    task automatic test_jump();
        fill_addi();
        put_at(32'h8, enc_jal(16), K_JAL, 16);
        put_at(32'h18, {25'h0000AB, 7'b1100111}, K_OTHER, 0);
        do_reset();
        cyc(); cyc(); cyc();
        n_checks++;
        if (out_pc !== 32'h8 || out_jump !== 1'b1 || out_branch !== 1'b0 ||
            out_pred_taken !== 1'b1 || out_pred_target !== 32'h18) begin
            n_fail++;
            $display("FAIL jump_pred: pc=%h j=%b br=%b pt=%b tgt=%h, expected 00000008 1 0 1 00000018",
                     out_pc, out_jump, out_branch, out_pred_taken, out_pred_target);
        end
        cyc();
        n_checks++;
        if (out_pc !== 32'h18 || out_jump !== 1'b0 || out_branch !== 1'b0 ||
            out_pred_taken !== 1'b0 || out_pred_target !== 32'h1C) begin
            n_fail++;
            $display("FAIL jump_jalr_next: pc=%h j=%b br=%b pt=%b tgt=%h, expected 00000018 0 0 0 0000001c",
                     out_pc, out_jump, out_branch, out_pred_taken, out_pred_target);
        end
    endtask

    task automatic test_training();
        fill_addi();
        put_at(32'h40, enc_br(32), K_BR, 32);
        do_reset();
        // Both commits land on counter 0x13; the redirect then sets the
        // speculative history to 3 so fetching 0x40 reads 3 ^ 0x10 = 0x13.
        commit_valid = 1; commit_taken = 1; commit_pc = 32'h4C;
        cyc();
        commit_pc = 32'h48; redirect_valid = 1; redirect_pc = 32'h40;
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL train_flush: valid=%b, expected 0", out_valid);
        end
        commit_valid = 0; redirect_valid = 0;
        cyc();
        n_checks++;
        if (out_pc !== 32'h40 || out_branch !== 1'b1 || out_pred_taken !== 1'b1 ||
            out_pred_target !== 32'h60) begin
            n_fail++;
            $display("FAIL train_pred: pc=%h br=%b pt=%b tgt=%h, expected 00000040 1 1 00000060",
                     out_pc, out_branch, out_pred_taken, out_pred_target);
        end
        cyc();
        n_checks++;
        if (out_pc !== 32'h60) begin
            n_fail++;
            $display("FAIL train_next: pc=%h, expected 00000060", out_pc);
        end
    endtask

    task automatic test_stall();
        fill_addi();
        do_reset();
        cyc(); cyc();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== enc_addi(1) ||
                out_pred_target !== 32'h8 || imem_addr !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid=%b pc=%h instr=%h tgt=%h addr=%h, expected 1 00000004 %h 00000008 00000008",
                         i, out_valid, out_pc, out_instr, out_pred_target, imem_addr, enc_addi(1));
            end
        end
        out_ready = 1;
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b pc=%h, expected 1 00000008", out_valid, out_pc);
        end
        out_ready = 0;
        cyc();
        reset = 0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_async_reset: valid=%b addr=%h, expected 0 00000000", out_valid, imem_addr);
        end
        model_reset();
        idle_inputs();
        #3;
        reset = 1;
    endtask

    task automatic test_redirect();
        fill_addi();
        do_reset();
        cyc(); cyc();
        redirect_valid = 1; redirect_pc = 32'h100;
        commit_valid = 1; commit_taken = 1; commit_pc = 32'h0;
        cyc();
        n_checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_flush: valid=%b addr=%h, expected 0 00000100", out_valid, imem_addr);
        end
        redirect_valid = 0; commit_valid = 0;
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_packet: valid=%b pc=%h, expected 1 00000100", out_valid, out_pc);
        end
        // Speculative history must now be 1: a branch at 0x200 reads
        // counter 1 ^ 0x80 = 0x81; train that counter with arch history 1.
        put_at(32'h200, enc_br(-8), K_BR, -8);
        commit_valid = 1; commit_taken = 1; commit_pc = 32'((32'h81 ^ 1) << 2);
        cyc();
        commit_pc = 32'((32'h81 ^ 3) << 2);
        cyc();
        commit_valid = 0; redirect_valid = 1; redirect_pc = 32'h200;
        // arch history is 7 after these commits; retarget the probe so the
        // fetch index is 7 ^ pc[11:2] = 0x81.
        redirect_pc = 32'((32'h81 ^ 7) << 2);
        put_at(redirect_pc, enc_br(-8), K_BR, -8);
        cyc();
        redirect_valid = 0;
        cyc();
        n_checks++;
        if (out_branch !== 1'b1 || out_pred_taken !== 1'b1 ||
            out_pred_target !== redirect_pc - 32'd8) begin
            n_fail++;
            $display("FAIL redirect_history: br=%b pt=%b tgt=%h, expected 1 1 %h",
                     out_branch, out_pred_taken, out_pred_target, redirect_pc - 32'd8);
        end
    endtask

    task automatic test_saturation();
        int a, idx;
        logic [31:0] p;
        fill_addi();
        do_reset();
        idx = 'h2A;
        a = 0;
        commit_valid = 1; commit_taken = 1;
        for (int i = 0; i < 5; i++) begin
            commit_pc = 32'((idx ^ a) << 2);
            cyc();
            a = (a * 2 + 1) % 1024;
        end
        // One not-taken: a saturated counter drops to 10 (still taken).
        commit_taken = 0;
        commit_pc = 32'((idx ^ a) << 2);
        a = (a * 2) % 1024;
        p = 32'((idx ^ a) << 2);
        put_at(p, enc_br(64), K_BR, 64);
        redirect_valid = 1; redirect_pc = p;
        cyc();
        commit_valid = 0; redirect_valid = 0;
        cyc();
        n_checks++;
        if (out_pc !== p || out_pred_taken !== 1'b1 || out_pred_target !== p + 32'd64) begin
            n_fail++;
            $display("FAIL saturate: pc=%h pt=%b tgt=%h, expected %h 1 %h",
                     out_pc, out_pred_taken, out_pred_target, p, p + 32'd64);
        end

        // Same-cycle read and write of counter 0x80 (value 01).
        fill_addi();
        put_at(32'h200, enc_br(64), K_BR, 64);
        put_at(32'h204, enc_br(64), K_BR, 64);
        do_reset();
        redirect_valid = 1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 0;
        commit_valid = 1; commit_taken = 1; commit_pc = 32'h200;
        cyc();
        n_checks++;
        if (out_pc !== 32'h200 || out_pred_taken !== 1'b0 || out_pred_target !== 32'h204) begin
            n_fail++;
            $display("FAIL collision_old: pc=%h pt=%b tgt=%h, expected 00000200 0 00000204",
                     out_pc, out_pred_taken, out_pred_target);
        end
        // The write did land: arch history 1, fetch 0x204 reads 1 ^ 0x81 = 0x80.
        commit_valid = 0;
        redirect_valid = 1; redirect_pc = 32'h204;
        cyc();
        redirect_valid = 0;
        cyc();
        n_checks++;
        if (out_pc !== 32'h204 || out_pred_taken !== 1'b1 || out_pred_target !== 32'h244) begin
            n_fail++;
            $display("FAIL collision_written: pc=%h pt=%b tgt=%h, expected 00000204 1 00000244",
                     out_pc, out_pred_taken, out_pred_target);
        end
    endtask

    task automatic test_random();
        int r, im, shown;
        shown = 0;
        for (int i = 0; i < 1024; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                put_idx(i, enc_addi(i), K_OTHER, 0);
            end else if (r < 70) begin
                im = (int'($urandom_range(0, 4095)) - 2048) * 2;
                put_idx(i, enc_br(im), K_BR, im);
            end else if (r < 80) begin
                im = (int'($urandom_range(0, 8191)) - 4096) * 2;
                put_idx(i, enc_jal(im), K_JAL, im);
            end else begin
                put_idx(i, enc_other(), K_OTHER, 0);
            end
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                                         : 32'($urandom_range(0, 1023)) << 2;
            commit_valid   = ($urandom_range(0, 2) == 0);
            commit_taken   = 1'($urandom_range(0, 1));
            commit_pc      = $urandom;
            cyc();
            n_checks++;
            if (imem_addr !== m_pc || out_valid !== m_ov ||
                (m_ov && (out_pc !== m_opc || out_instr !== m_oinstr || out_branch !== m_obr ||
                          out_jump !== m_oj || out_pred_taken !== m_opt ||
                          out_pred_target !== m_otgt))) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_c%0d: addr=%h v=%b pc=%h br=%b j=%b pt=%b tgt=%h, expected addr=%h v=%b pc=%h br=%b j=%b pt=%b tgt=%h",
                             c, imem_addr, out_valid, out_pc, out_branch, out_jump, out_pred_taken,
                             out_pred_target, m_pc, m_ov, m_opc, m_obr, m_oj, m_opt, m_otgt);
                end
            end
        end
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        test_reset();
        test_stream();
        test_jump();
        test_training();
        test_stall();
        test_redirect();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
